// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Sequential instruction fetch front end. A PC register addresses a
// combinational instruction memory. Each returned word is buffered together
// with its address in a 2-entry FIFO, and the consumer drains that FIFO with
// a valid/ready handshake. A redirect flushes the buffer and reloads the PC.
// Fetching a HALT_WORD stops further fetches until the next redirect.
//
// Parameters
//   RESET_PC        PC loaded on reset (low two bits forced to zero)
//   HALT_WORD       fetched word that halts fetching (default EBREAK)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   fetch_en        allows new fetches when high
//   redirect_valid  single-cycle branch/jump redirect request
//   redirect_pc     redirect target (low two bits ignored)
//   imem_addr       instruction memory address (the PC register)
//   imem_instr      word returned by memory in the same cycle
//   out_valid       FIFO holds at least one entry
//   out_ready       consumer accepts the head entry
//   out_instr       head-entry instruction
//   out_pc          head-entry address
//   halted          high while fetching is halted
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'h0010_0073
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   // Entry 0 is always the head; entry 1 is only meaningful when count_q==2.
   entry_t      fifo_q [2];
   entry_t      fifo_d [2];

   logic        pop;
   logic        push;
   logic [1:0]  fill;       // occupancy after this cycle's pop, before push

   // NOTE: every signal written here gets a default first, so no path
   // through the branches below can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      fifo_d  = fifo_q;

      // A redirect overrides both handshakes for the cycle.
      pop  = (count_q != 2'd0) && out_ready && !redirect_valid;
      push = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
             ((count_q != 2'd2) || pop);
      fill = count_q - {1'b0, pop};

      if (redirect_valid) begin
         count_d = 2'd0;
         pc_d    = redirect_pc & ALIGN_MASK;
         state_d = ST_RUN;
      end else begin
         // Shift first so that a simultaneous push lands behind the
         // surviving entry and FIFO order is preserved.
         if (pop) begin
            fifo_d[0] = fifo_q[1];
         end
         if (push) begin
            fifo_d[fill[0]] = '{pc: pc_q, instr: imem_instr};
            pc_d            = pc_q + 32'd4;
            if (imem_instr == HALT_WORD) begin
               state_d = ST_HALT;
            end
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: the FIFO storage is reset as well as the control state, because
   // out_instr/out_pc read it directly and must be zero while in reset.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values computed before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         pc_q      <= RESET_PC & ALIGN_MASK;
         count_q   <= 2'd0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         fifo_q[0] <= fifo_d[0];
         fifo_q[1] <= fifo_d[1];
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (count_q != 2'd0);
   assign out_instr = fifo_q[0].instr;
   assign out_pc    = fifo_q[0].pc;
   assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//
// Bench for instr_fetch_ctrl: directed vector tables for the documented
// scenarios, a hand-written wrap-around sequence on a second instance with
// RESET_PC at the top of the address space, and a random phase compared
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

   localparam logic [31:0] HALT = 32'h0010_0073;
   localparam logic [31:0] M0   = 32'hF0F0_A5A5;
   localparam logic [31:0] M1   = 32'h0000_0013;
   localparam logic [31:0] M2   = 32'hFF00_FF00;
   localparam logic [31:0] M3   = 32'hA000_0003;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
   logic        out_valid, halted;

   logic [31:0] w_addr, w_imem, w_instr, w_pc;
   logic        w_valid, w_halted, w_ready;

   // Instruction memory: 64 words, aliased across the address space.
   logic [31:0] mem [64];

   assign imem_instr = mem[imem_addr[7:2]];
   assign w_imem     = mem[w_addr[7:2]];
   assign w_ready    = 1'b1;

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
   );

   instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(w_addr), .imem_instr(w_imem),
      .out_valid(w_valid), .out_ready(w_ready),
      .out_instr(w_instr), .out_pc(w_pc), .halted(w_halted)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;         // pulse reset between edges instead of clocking
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_addr;
      logic        exp_halted;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic fe, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ein,
                              input logic [31:0] ea, input logic eh);
      vec_t r;
      r = '{rst: 1'b0, fe: fe, rdy: rdy, rv: rv, rpc: rpc, exp_valid: ev,
            exp_pc: epc, exp_instr: ein, exp_addr: ea, exp_halted: eh};
      return r;
   endfunction

   function automatic vec_t rst_row();
      vec_t r;
      r = '{rst: 1'b1, fe: 1'b0, rdy: 1'b0, rv: 1'b0, rpc: 32'h0,
            exp_valid: 1'b0, exp_pc: 32'h0, exp_instr: 32'h0,
            exp_addr: 32'h0, exp_halted: 1'b0};
      return r;
   endfunction

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
   endtask

   task automatic run_vecs(input string tag);
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            pulse_reset();
            // Observed while rst_n is still low, before any clock edge.
            check($sformatf("%s[%0d] rst out_pc", tag, i), out_pc, 32'h0);
            check($sformatf("%s[%0d] rst out_instr", tag, i), out_instr, 32'h0);
         end else begin
            fetch_en       = vecs[i].fe;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            #1;
         end
         check($sformatf("%s[%0d] out_valid", tag, i), out_valid, vecs[i].exp_valid);
         check($sformatf("%s[%0d] imem_addr", tag, i), imem_addr, vecs[i].exp_addr);
         check($sformatf("%s[%0d] halted", tag, i), halted, vecs[i].exp_halted);
         if (vecs[i].exp_valid) begin
            check($sformatf("%s[%0d] out_pc", tag, i), out_pc, vecs[i].exp_pc);
            check($sformatf("%s[%0d] out_instr", tag, i), out_instr, vecs[i].exp_instr);
         end
         if (vecs[i].rst) begin
            #1 rst_n = 1'b1;
         end
      end
      redirect_valid = 1'b0;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   bit          m_halt;

   task automatic model_reset();
      m_q.delete();
      m_pc   = 32'h0;
      m_halt = 1'b0;
   endtask

   // Advances the model by one clock using the inputs as they stand now.
   task automatic model_step();
      bit          pop, push;
      logic [31:0] word;
      ent_t        tmp;
      pop  = (m_q.size() != 0) && out_ready && !redirect_valid;
      push = !m_halt && fetch_en && !redirect_valid && (m_q.size() < 2 || pop);
      word = mem[m_pc[7:2]];
      if (redirect_valid) begin
         m_q.delete();
         m_pc   = {redirect_pc[31:2], 2'b00};
         m_halt = 1'b0;
      end else begin
         if (pop) tmp = m_q.pop_front();
         if (push) begin
            m_q.push_back('{pc: m_pc, instr: word});
            if (word == HALT) m_halt = 1'b1;
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
      mem[0] = M0;
      mem[1] = M1;
      mem[2] = M2;

      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Table A: in-order streaming, back-pressure stall, reset with a full
      // buffer, redirect while full, fetch_en low.
      vecs.push_back(rst_row());
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h4, M1, 32'h8, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h8, M2, 32'hC, 0));
      vecs.push_back(rst_row());
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h8, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h4, M1, 32'hC, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h8, M2, 32'h10, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'hC, M3, 32'h14, 0));
      vecs.push_back(rst_row());
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h8, 0));
      vecs.push_back(rst_row());
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h8, 0));
      vecs.push_back(v(1, 1, 1, 32'hB, 0, 32'h0, 32'h0, 32'h8, 0));
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h8, M2, 32'hC, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 0));
      run_vecs("tblA");

      // Table B: halt word at 0x4, drain while halted, redirect to resume.
      mem[1] = HALT;
      vecs.delete();
      vecs.push_back(rst_row());
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h8, 1));
      vecs.push_back(v(1, 0, 0, 0, 1, 32'h0, M0, 32'h8, 1));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h4, HALT, 32'h8, 1));
      vecs.push_back(v(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h8, 1));
      vecs.push_back(v(1, 1, 1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
      vecs.push_back(v(1, 1, 0, 0, 1, 32'h0, M0, 32'h4, 0));
      run_vecs("tblB");
      mem[1] = M1;

      // Wrap-around of the PC from the top of the address space.
      pulse_reset();
      check("wrap rst addr", w_addr, 32'hFFFF_FFFC);
      check("wrap rst valid", w_valid, 1'b0);
      #1 rst_n = 1'b1;
      fetch_en = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk); #1;
      check("wrap addr1", w_addr, 32'h0);
      check("wrap head pc", w_pc, 32'hFFFF_FFFC);
      check("wrap head instr", w_instr, mem[63]);
      @(posedge clk); #1;
      check("wrap addr2", w_addr, 32'h4);
      check("wrap head pc2", w_pc, 32'h0);

      // Random phase against the reference model.
      for (int i = 0; i < 64; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      pulse_reset();
      #1 rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         fetch_en       = ($urandom_range(0, 9) < 8);
         out_ready      = ($urandom_range(0, 9) < 6);
         redirect_valid = ($urandom_range(0, 29) == 0);
         redirect_pc    = $urandom_range(0, 255);
         model_step();
         @(posedge clk);
         #1;
         check("rand out_valid", out_valid, (m_q.size() != 0));
         check("rand imem_addr", imem_addr, m_pc);
         check("rand halted", halted, m_halt);
         if (m_q.size() != 0) begin
            check("rand out_pc", out_pc, m_q[0].pc);
            check("rand out_instr", out_instr, m_q[0].instr);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
